exu_commit: RTL and testbench

Back end of the integer execute stage. Sits directly after the ALU and accepts one resolved micro-op per handshake. Each op carries its result, branch decision, PC, immediate and rs1. The block computes control-transfer targets, issues a one-cycle front-end redirect for taken branches and jumps, and buffers writeback data in a 2-entry FIFO toward the register file.

---
 rtl/exu_commit.sv | 184 ++++++++++++++++++
 tb/tb_exu_commit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_commit.sv
// exu_commit -- back end of the integer execute stage.
//
// Takes one resolved micro-op per handshake from the ALU, works out the
// control-transfer target, raises a one-cycle fetch redirect for taken
// branches and jumps, and buffers writeback data in a 2-entry FIFO that
// drains toward the register file.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   ex_valid_i/ex_ready_o   EX op handshake
//   ex_pc_i, ex_imm_i       op PC and sign-extended immediate
//   ex_rs1_i                JALR base operand
//   ex_alu_res_i            ALU result (pc+4 for JAL/JALR)
//   ex_jump_i               branch condition result
//   ex_is_branch_i/_jal_i/_jalr_i  op class, one-hot or all zero
//   ex_rd_i, ex_rd_we_i     destination register and its write request
//   wb_valid_o/wb_ready_i   writeback FIFO head handshake
//   wb_rd_o, wb_we_o, wb_data_o  FIFO head contents
//   redirect_valid_o/_pc_o  one-cycle fetch redirect pulse and target
//   trap_valid_o/_pc_o      misaligned-target trap pulse and faulting PC
//
// Configuration macro:
//   EXU_COMMIT_MISALIGN_CHK_EN  when defined, a redirecting op whose target
//                               has bit 1 set traps instead of redirecting
//                               and its writeback is suppressed. When
//                               undefined the trap outputs are tied to 0.

module exu_commit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic [XLEN-1:0] ex_rs1_i,
  input  logic [XLEN-1:0] ex_alu_res_i,
  input  logic            ex_jump_i,
  input  logic            ex_is_branch_i,
  input  logic            ex_is_jal_i,
  input  logic            ex_is_jalr_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_rd_we_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic            wb_we_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_valid_o,
  output logic [XLEN-1:0] trap_pc_o
);

  // FIFO state
  logic            mem_rd   [2];
  logic [4:0]      mem_rdx  [2];
  logic            mem_we   [2];
  logic [XLEN-1:0] mem_data [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;

  logic            full;
  logic            empty;
  logic            accept;
  logic            push;
  logic            pop;

  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic            take;
  logic            misalign;
  logic            do_redirect;
  logic            entry_we;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

  // Ready uses the registered count, so a pop in the full cycle only frees
  // a slot for the following cycle. Pulse cycles stall to drop the young op.
  assign ex_ready_o = ~full & ~redirect_valid_o & ~trap_valid_o;
  assign accept     = ex_valid_i & ex_ready_o;
  assign push       = accept;
  assign pop        = wb_valid_o & wb_ready_i;

  // Target arithmetic wraps modulo 2^XLEN; JALR clears bit 0 of the sum.
  assign br_target   = ex_pc_i + ex_imm_i;
  assign jalr_sum    = ex_rs1_i + ex_imm_i;
  assign jalr_target = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
  assign target      = ex_is_jalr_i ? jalr_target : br_target;

  assign take = (ex_is_branch_i & ex_jump_i) | ex_is_jal_i | ex_is_jalr_i;

`ifdef EXU_COMMIT_MISALIGN_CHK_EN
  assign misalign = take & target[1];
`else
  assign misalign = 1'b0;
`endif

  assign do_redirect = take & ~misalign;

  // x0 writes, branches and trapping ops never update the register file.
  assign entry_we = ex_rd_we_i & (ex_rd_i != 5'd0) & ~ex_is_branch_i & ~misalign;

  // Redirect pulse: registered so it appears only in the cycle after accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      redirect_valid_o <= accept & do_redirect;
      if (accept & do_redirect) begin
        redirect_pc_o <= target;
      end
    end
  end

`ifdef EXU_COMMIT_MISALIGN_CHK_EN
  // Trap pulse for misaligned control-transfer targets, carrying the op PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trap_valid_o <= 1'b0;
      trap_pc_o    <= '0;
    end else begin
      trap_valid_o <= accept & misalign;
      if (accept & misalign) begin
        trap_pc_o <= ex_pc_i;
      end
    end
  end
`else
  assign trap_valid_o = 1'b0;
  assign trap_pc_o    = '0;
`endif

  // FIFO storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        mem_rdx[i]  <= 5'd0;
        mem_we[i]   <= 1'b0;
        mem_data[i] <= '0;
        mem_rd[i]   <= 1'b0;
      end
    end else if (push) begin
      mem_rdx[wr_ptr]  <= ex_rd_i;
      mem_we[wr_ptr]   <= entry_we;
      mem_data[wr_ptr] <= ex_alu_res_i;
      mem_rd[wr_ptr]   <= 1'b1;
    end
  end

  // Pointers are single bits and wrap naturally; count tracks occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Head outputs come straight from storage, never bypassed from the input.
  assign wb_valid_o = ~empty;
  assign wb_rd_o    = mem_rdx[rd_ptr];
  assign wb_we_o    = mem_we[rd_ptr] & mem_rd[rd_ptr];
  assign wb_data_o  = mem_data[rd_ptr];

endmodule

// File: tb/tb_exu_commit.sv
// tb_exu_commit -- scoreboard bench for exu_commit.
//
// Directed ops are issued with hand-computed expected writeback entries,
// redirect targets and trap PCs. A monitor records expectations when the
// input handshake completes and pops/compares them whenever the DUT
// presents a writeback, redirect or trap. Directed checks cover reset
// values, pulse timing and FIFO back-pressure.

module tb_exu_commit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_imm_i;
  logic [31:0] ex_rs1_i;
  logic [31:0] ex_alu_res_i;
  logic        ex_jump_i;
  logic        ex_is_branch_i;
  logic        ex_is_jal_i;
  logic        ex_is_jalr_i;
  logic [4:0]  ex_rd_i;
  logic        ex_rd_we_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic        wb_we_o;
  logic [31:0] wb_data_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        trap_valid_o;
  logic [31:0] trap_pc_o;

  exu_commit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .ex_pc_i(ex_pc_i), .ex_imm_i(ex_imm_i), .ex_rs1_i(ex_rs1_i),
    .ex_alu_res_i(ex_alu_res_i), .ex_jump_i(ex_jump_i),
    .ex_is_branch_i(ex_is_branch_i), .ex_is_jal_i(ex_is_jal_i),
    .ex_is_jalr_i(ex_is_jalr_i), .ex_rd_i(ex_rd_i), .ex_rd_we_i(ex_rd_we_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .trap_valid_o(trap_valid_o), .trap_pc_o(trap_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_t;

  wb_t         wb_q[$];
  logic [31:0] redir_q[$];
  logic [31:0] trap_q[$];

  int tests    = 0;
  int failures = 0;

  // Expectations for the op currently on the input port.
  logic [4:0]  exp_rd;
  logic        exp_we;
  logic [31:0] exp_data;
  logic        exp_redir;
  logic [31:0] exp_rpc;
  logic        exp_trap;
  logic [31:0] exp_tpc;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic reportUnexpected(input string name);
    tests++;
    failures++;
    $display("[TB] FAIL %s: got unexpected output, expected none", name);
  endtask

  // Monitor: pop and compare on every DUT output event, then record the
  // expectations of any op accepted on this cycle's edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      wb_q.delete();
      redir_q.delete();
      trap_q.delete();
    end else begin
      if (wb_valid_o && wb_ready_i) begin
        if (wb_q.size() == 0) begin
          reportUnexpected("wb_pop");
        end else begin
          wb_t e;
          e = wb_q.pop_front();
          checkOutput("sb_wb_rd", 32'(wb_rd_o), 32'(e.rd));
          checkOutput("sb_wb_we", 32'(wb_we_o), 32'(e.we));
          checkOutput("sb_wb_data", wb_data_o, e.data);
        end
      end
      if (redirect_valid_o) begin
        if (redir_q.size() == 0) reportUnexpected("redirect");
        else checkOutput("sb_redirect_pc", redirect_pc_o, redir_q.pop_front());
      end
      if (trap_valid_o) begin
        if (trap_q.size() == 0) reportUnexpected("trap");
        else checkOutput("sb_trap_pc", trap_pc_o, trap_q.pop_front());
      end
      if (ex_valid_i && ex_ready_o) begin
        wb_q.push_back('{rd: exp_rd, we: exp_we, data: exp_data});
        if (exp_redir) redir_q.push_back(exp_rpc);
        if (exp_trap)  trap_q.push_back(exp_tpc);
      end
    end
  end

  task automatic setOp(input logic [31:0] pc, imm, rs1, res,
                       input logic jump, br, jal, jalr,
                       input logic [4:0] rd, input logic rdwe,
                       input logic ewe, input logic eredir, input logic [31:0] erpc,
                       input logic etrap);
    ex_pc_i = pc; ex_imm_i = imm; ex_rs1_i = rs1; ex_alu_res_i = res;
    ex_jump_i = jump; ex_is_branch_i = br; ex_is_jal_i = jal; ex_is_jalr_i = jalr;
    ex_rd_i = rd; ex_rd_we_i = rdwe;
    exp_rd = rd; exp_we = ewe; exp_data = res;
    exp_redir = eredir; exp_rpc = erpc; exp_trap = etrap; exp_tpc = pc;
    ex_valid_i = 1'b1;
  endtask

  task automatic clearOp();
    ex_valid_i = 1'b0; ex_is_branch_i = 1'b0; ex_is_jal_i = 1'b0;
    ex_is_jalr_i = 1'b0; ex_jump_i = 1'b0; ex_rd_we_i = 1'b0;
  endtask

  // Present one op and hold it until accepted; returns #1 after the
  // accepting edge, i.e. inside cycle N+1.
  task automatic applyStimulus(input logic [31:0] pc, imm, rs1, res,
                               input logic jump, br, jal, jalr,
                               input logic [4:0] rd, input logic rdwe,
                               input logic ewe, input logic eredir, input logic [31:0] erpc,
                               input logic etrap);
    bit done = 0;
    setOp(pc, imm, rs1, res, jump, br, jal, jalr, rd, rdwe, ewe, eredir, erpc, etrap);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk_i);
      if (ex_ready_o) done = 1;
      @(posedge clk_i);
      #1;
    end
    if (!done) reportUnexpected("accept_timeout");
    clearOp();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_wb_valid"}, 32'(wb_valid_o), 32'd0);
    checkOutput({tag, "_wb_we"}, 32'(wb_we_o), 32'd0);
    checkOutput({tag, "_wb_rd"}, 32'(wb_rd_o), 32'd0);
    checkOutput({tag, "_wb_data"}, wb_data_o, 32'd0);
    checkOutput({tag, "_redir_valid"}, 32'(redirect_valid_o), 32'd0);
    checkOutput({tag, "_redir_pc"}, redirect_pc_o, 32'd0);
    checkOutput({tag, "_trap_valid"}, 32'(trap_valid_o), 32'd0);
    checkOutput({tag, "_trap_pc"}, trap_pc_o, 32'd0);
    checkOutput({tag, "_ex_ready"}, 32'(ex_ready_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    wb_ready_i = 1'b1;
    ex_pc_i = '0; ex_imm_i = '0; ex_rs1_i = '0; ex_alu_res_i = '0; ex_rd_i = '0;
    exp_rd = '0; exp_we = 0; exp_data = '0; exp_redir = 0; exp_rpc = '0;
    exp_trap = 0; exp_tpc = '0;
    clearOp();
    #1;
    checkResetValues("reset");
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // ADD rd=5
    applyStimulus(32'h0000_0100, 32'h0, 32'h0, 32'h0000_1234, 0, 0, 0, 0, 5'd5, 1,
                  1, 0, 32'h0, 0);
    checkOutput("add_wb_valid", 32'(wb_valid_o), 32'd1);
    checkOutput("add_wb_rd", 32'(wb_rd_o), 32'd5);
    checkOutput("add_wb_we", 32'(wb_we_o), 32'd1);
    checkOutput("add_wb_data", wb_data_o, 32'h0000_1234);

    // ADD rd=0: write enable suppressed
    applyStimulus(32'h0000_0104, 32'h0, 32'h0, 32'h0000_5678, 0, 0, 0, 0, 5'd0, 1,
                  0, 0, 32'h0, 0);
    checkOutput("add_x0_wb_we", 32'(wb_we_o), 32'd0);
    checkOutput("add_x0_wb_data", wb_data_o, 32'h0000_5678);

    // BEQ taken, negative offset
    applyStimulus(32'h8000_0010, 32'hFFFF_FFF0, 32'h0, 32'h0000_0001, 1, 1, 0, 0, 5'd0, 0,
                  0, 1, 32'h8000_0000, 0);
    checkOutput("beq_redir_valid", 32'(redirect_valid_o), 32'd1);
    checkOutput("beq_redir_pc", redirect_pc_o, 32'h8000_0000);
    checkOutput("beq_ready_low", 32'(ex_ready_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("beq_redir_gone", 32'(redirect_valid_o), 32'd0);
    checkOutput("beq_ready_back", 32'(ex_ready_o), 32'd1);

    // BEQ not taken: no pulse
    applyStimulus(32'h8000_0020, 32'h0000_0040, 32'h0, 32'h0, 0, 1, 0, 0, 5'd0, 0,
                  0, 0, 32'h0, 0);
    checkOutput("bne_no_redir", 32'(redirect_valid_o), 32'd0);
    checkOutput("bne_ready", 32'(ex_ready_o), 32'd1);

    // JALR: (0x8000_0101 + 4) & ~1 = 0x8000_0104, rd=1 gets pc+4
    applyStimulus(32'h8000_0200, 32'h0000_0004, 32'h8000_0101, 32'h8000_0204, 0, 0, 0, 1,
                  5'd1, 1, 1, 1, 32'h8000_0104, 0);
    checkOutput("jalr_redir_valid", 32'(redirect_valid_o), 32'd1);
    checkOutput("jalr_redir_pc", redirect_pc_o, 32'h8000_0104);
    checkOutput("jalr_wb_rd", 32'(wb_rd_o), 32'd1);
    checkOutput("jalr_wb_data", wb_data_o, 32'h8000_0204);
    @(posedge clk_i); #1;

    // JAL with target wrap-around: 0xFFFF_FFFC + 8 = 0x0000_0004
    applyStimulus(32'hFFFF_FFFC, 32'h0000_0008, 32'h0, 32'h0000_0000, 0, 0, 1, 0,
                  5'd2, 1, 1, 1, 32'h0000_0004, 0);
    checkOutput("jal_wrap_redir_pc", redirect_pc_o, 32'h0000_0004);
    @(posedge clk_i); #1;

    // Back-pressure: two ADDs fill the FIFO, third is held
    wb_ready_i = 1'b0;
    applyStimulus(32'h0000_0300, 32'h0, 32'h0, 32'hAAAA_0001, 0, 0, 0, 0, 5'd7, 1,
                  1, 0, 32'h0, 0);
    applyStimulus(32'h0000_0304, 32'h0, 32'h0, 32'hAAAA_0002, 0, 0, 0, 0, 5'd8, 1,
                  1, 0, 32'h0, 0);
    checkOutput("full_ready_low", 32'(ex_ready_o), 32'd0);
    checkOutput("full_head_rd", 32'(wb_rd_o), 32'd7);
    setOp(32'h0000_0308, 32'h0, 32'h0, 32'hAAAA_0003, 0, 0, 0, 0, 5'd9, 1,
          1, 0, 32'h0, 0);
    repeat (2) begin
      @(posedge clk_i); #1;
      checkOutput("full_held", 32'(ex_ready_o), 32'd0);
    end
    wb_ready_i = 1'b1;
    #1;
    checkOutput("full_pop_cycle_ready", 32'(ex_ready_o), 32'd0);
    @(posedge clk_i); #1;
    checkOutput("after_pop_ready", 32'(ex_ready_o), 32'd1);
    checkOutput("after_pop_head_rd", 32'(wb_rd_o), 32'd8);
    @(posedge clk_i); #1;
    clearOp();
    checkOutput("third_head_rd", 32'(wb_rd_o), 32'd9);
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("drained_empty", 32'(wb_valid_o), 32'd0);

`ifdef EXU_COMMIT_MISALIGN_CHK_EN
    // JAL to 0x8000_0002: trap instead of redirect, writeback suppressed
    applyStimulus(32'h8000_0000, 32'h0000_0002, 32'h0, 32'h8000_0004, 0, 0, 1, 0,
                  5'd1, 1, 0, 0, 32'h0, 1);
    checkOutput("mis_trap_valid", 32'(trap_valid_o), 32'd1);
    checkOutput("mis_trap_pc", trap_pc_o, 32'h8000_0000);
    checkOutput("mis_no_redir", 32'(redirect_valid_o), 32'd0);
    checkOutput("mis_wb_we", 32'(wb_we_o), 32'd0);
    checkOutput("mis_ready_low", 32'(ex_ready_o), 32'd0);
`else
    // Without the check the same JAL redirects unchanged
    applyStimulus(32'h8000_0000, 32'h0000_0002, 32'h0, 32'h8000_0004, 0, 0, 1, 0,
                  5'd1, 1, 1, 1, 32'h8000_0002, 0);
    checkOutput("nomis_redir_pc", redirect_pc_o, 32'h8000_0002);
    checkOutput("nomis_trap_valid", 32'(trap_valid_o), 32'd0);
    checkOutput("nomis_wb_we", 32'(wb_we_o), 32'd1);
`endif
    @(posedge clk_i); #1;

    // Reset while a redirect pulse is pending and the FIFO holds an entry
    wb_ready_i = 1'b0;
    applyStimulus(32'h0000_1000, 32'h0000_0100, 32'h0, 32'h0000_1004, 0, 0, 1, 0,
                  5'd3, 1, 1, 1, 32'h0000_1100, 0);
    checkOutput("pre_reset_redir", 32'(redirect_valid_o), 32'd1);
    checkOutput("pre_reset_wb_valid", 32'(wb_valid_o), 32'd1);
    rst_i = 1'b1;
    #1;
    checkResetValues("midreset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    wb_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checkResetValues("postreset");

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("sb_wb_left", 32'(wb_q.size()), 32'd0);
    checkOutput("sb_redir_left", 32'(redir_q.size()), 32'd0);
    checkOutput("sb_trap_left", 32'(trap_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
